// File: rtl/aes_subbytes_shiftrows.sv
// aes_subbytes_shiftrows: multi-cycle SubBytes+ShiftRows (or the inverse pair)
// for the AES round datapath. SBOX_LANES S-box lanes are time-multiplexed over
// the 16 state bytes; each substituted byte lands directly on its ShiftRows
// destination in the output register.
// Build option: define AES_SUBBYTES_SCRUB_EN to clear the captured input and
// the output register when the result is handed off.
module aes_subbytes_shiftrows #(
    parameter int SBOX_LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_dec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    localparam int NCYC = 16 / SBOX_LANES;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
          SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
        $error("SBOX_LANES must be 1, 2, 4, 8 or 16");
    end

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as AES requires
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    // Forward S-box = affine(inv(x)); inverse S-box = inv(inv_affine(y))
    function automatic logic [7:0] sbox(input logic [7:0] b, input logic dec);
        logic [7:0] t;
        if (dec) begin
            t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
            return ginv(t);
        end
        t = ginv(b);
        return t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]} ^
               {t[3:0], t[7:4]} ^ 8'h63;
    endfunction

    // Byte k of the state is element [15-k] (byte 0 is the MSB byte)
    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dec_q, dec_d;
    logic [15:0][7:0] in_q, in_d;
    logic [15:0][7:0] out_q, out_d;

    logic [SBOX_LANES-1:0][3:0] src_w;
    logic [SBOX_LANES-1:0][3:0] dst_w;
    logic [SBOX_LANES-1:0][7:0] sub_w;

    // Per lane: source byte, its ShiftRows destination, and the substitution
    for (genvar l = 0; l < SBOX_LANES; l++) begin : g_lane
        assign src_w[l] = 4'(int'(cnt_q) * SBOX_LANES + l);
        // src = r + 4c with r = src[1:0], c = src[3:2]; column arithmetic wraps mod 4
        assign dst_w[l] = {dec_q ? (src_w[l][3:2] + src_w[l][1:0])
                                 : (src_w[l][3:2] - src_w[l][1:0]), src_w[l][1:0]};
        assign sub_w[l] = sbox(in_q[4'd15 - src_w[l]], dec_q);
    end

    // Control FSM: capture in IDLE, walk the byte counter in RUN, hold in DONE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        in_d    = in_q;
        case (state_q)
            S_IDLE: if (in_valid) begin
                in_d    = in_state;
                dec_d   = in_dec;
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: if (cnt_q == CW'(NCYC - 1)) begin
                cnt_d   = '0;
                state_d = S_DONE;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            S_DONE: if (out_ready) begin
                state_d = S_IDLE;
`ifdef AES_SUBBYTES_SCRUB_EN
                in_d = '0;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output register: scatter this cycle's lane results; other bytes hold
    always_comb begin
        out_d = out_q;
        if (state_q == S_RUN) begin
            for (int l = 0; l < SBOX_LANES; l++) begin
                out_d[4'd15 - dst_w[l]] = sub_w[l];
            end
        end
`ifdef AES_SUBBYTES_SCRUB_EN
        if (state_q == S_DONE && out_ready) out_d = '0;
`endif
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            in_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            in_q    <= in_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN);
    assign out_state = out_q;

endmodule

// File: tb/tb_aes_subbytes_shiftrows.sv
// Directed bench: three builds (1, 4, 16 lanes) share the input side; each is
// checked for result, latency, backpressure, async reset and retention.
module tb_aes_subbytes_shiftrows;
    localparam logic [127:0] V_PT  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] V_SB  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] V_63  = {16{8'h63}};
    localparam logic [127:0] V_Z   = 128'h0;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] in_state = '0;
    logic         in_dec = 1'b0;
    logic         out_ready = 1'b0;
    logic         ir[3];
    logic         ov[3];
    logic         bz[3];
    logic [127:0] os[3];
    int           nc[3] = '{16, 4, 1};
    int           lat[3];
    int           n_chk = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    aes_subbytes_shiftrows #(.SBOX_LANES(1)) u_l1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_state(in_state),
        .in_dec(in_dec), .out_valid(ov[0]), .out_ready(out_ready), .out_state(os[0]), .busy(bz[0]));
    aes_subbytes_shiftrows #(.SBOX_LANES(4)) u_l4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_state(in_state),
        .in_dec(in_dec), .out_valid(ov[1]), .out_ready(out_ready), .out_state(os[1]), .busy(bz[1]));
    aes_subbytes_shiftrows #(.SBOX_LANES(16)) u_l16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_state(in_state),
        .in_dec(in_dec), .out_valid(ov[2]), .out_ready(out_ready), .out_state(os[2]), .busy(bz[2]));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [127:0] exp_os);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("%s_ready[L%0d]", tag, 16 / nc[j]), 128'(ir[j]), 128'd1);
            chk($sformatf("%s_valid[L%0d]", tag, 16 / nc[j]), 128'(ov[j]), 128'd0);
            chk($sformatf("%s_busy[L%0d]",  tag, 16 / nc[j]), 128'(bz[j]), 128'd0);
            chk($sformatf("%s_state[L%0d]", tag, 16 / nc[j]), os[j], exp_os);
        end
    endtask

    // Accept one block on every build and wait (bounded) until all reach DONE
    task automatic run_block(input string tag, input logic [127:0] st, input logic dec,
                             input logic [127:0] exp);
        in_state  = st;
        in_dec    = dec;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_dec   = ~dec;      // mid-block changes must not matter
        in_state = ~st;
        for (int j = 0; j < 3; j++) lat[j] = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            for (int j = 0; j < 3; j++) if (ov[j] && lat[j] == 0) lat[j] = cyc;
        end
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("%s_lat[L%0d]",   tag, 16 / nc[j]), 128'(lat[j]), 128'(nc[j]));
            chk($sformatf("%s_data[L%0d]",  tag, 16 / nc[j]), os[j], exp);
            chk($sformatf("%s_ready[L%0d]", tag, 16 / nc[j]), 128'(ir[j]), 128'd0);
        end
    endtask

    task automatic release_out(input string tag, input logic [127:0] exp_os);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk_idle(tag, exp_os);
    endtask

    initial begin
        logic [127:0] ret_exp;
        #1 rst = 1'b1;
        #2 chk_idle("reset", V_Z);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_block("enc_fips", V_PT, 1'b0, V_SB);
        release_out("rel_fips", V_SB);
        run_block("dec_fips", V_SB, 1'b1, V_PT);
        release_out("rel_dfips", V_PT);

        // Backpressure: hold DONE for 20 cycles while the input side churns
        run_block("enc_zero", V_Z, 1'b0, V_63);
        for (int cyc = 0; cyc < 20; cyc++) begin
            in_valid = cyc[0];
            in_dec   = ~in_dec;
            in_state = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            chk("bp_valid", 128'(ov[1]), 128'd1);
            chk("bp_state", os[1], V_63);
            chk("bp_ready", 128'(ir[1]), 128'd0);
        end
        in_valid = 1'b0;
`ifdef AES_SUBBYTES_SCRUB_EN
        ret_exp = V_Z;
`else
        ret_exp = V_63;
`endif
        release_out("retain", ret_exp);

        run_block("dec_63", V_63, 1'b1, V_Z);
        release_out("rel_63", V_Z);

        // Async reset with the 4-lane build at counter==2
        in_state = V_PT;
        in_dec   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_busy_l1", 128'(bz[0]), 128'd1);
        chk("pre_rst_busy_l4", 128'(bz[1]), 128'd1);
        chk("pre_rst_valid_l16", 128'(ov[2]), 128'd1);
        #1 rst = 1'b1;
        #1 chk_idle("midrst", V_Z);
        #1 rst = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(posedge clk); #1;
            for (int j = 0; j < 3; j++)
                chk($sformatf("no_spur[L%0d]", 16 / nc[j]), 128'(ov[j]), 128'd0);
        end
        run_block("post_rst", V_SB, 1'b1, V_PT);
        release_out("rel_post", V_PT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
